// File: rtl/game_time_display.sv
// Live/lap time display: converts the 0.1 s game count to BCD with a bit-serial
// double-dabble engine and drives four 7-segment digits showing "XXX.X".
module game_time_display #(
    parameter int IN_W          = 10,
    parameter bit BLANK_LEADING = 1'b1,
    parameter bit SEG_ACT_LOW   = 1'b1
) (
    input  logic            CLOCK50M,
    input  logic            KEY0,
    input  logic [IN_W-1:0] counter_in,
    input  logic            counter_update,
    input  logic            write_100m,
    input  logic            show_lap,
    output logic [15:0]     bcd_out,
    output logic [15:0]     lap_bcd,
    output logic            lap_valid,
    output logic            busy,
    output logic            conv_done,
    output logic [6:0]      HEX0,
    output logic [6:0]      HEX1,
    output logic [6:0]      HEX2,
    output logic [6:0]      HEX3
);

    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [IN_W-1:0] sr_q, sr_d;
    logic [IN_W-1:0] hold_q, hold_d;
    logic [15:0]     scr_q, scr_d;
    logic [15:0]     bcd_q, bcd_d;
    logic [15:0]     lap_q, lap_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            upd_pend_q, upd_pend_d;
    logic            lap_pend_q, lap_pend_d;
    logic            lap_valid_q, lap_valid_d;
    logic            done_q, done_d;
    logic [3:0][6:0] hex_q, hex_d;

    logic            in_idle, in_shift, in_done;
    logic            start;
    logic [IN_W-1:0] start_val;
    logic [15:0]     adj;
    logic [15:0]     src;
    logic            blank3, blank2;

    function automatic logic [6:0] seg7(input logic [3:0] d, input logic blank);
        logic [6:0] raw;
        case (d)
            4'd0:    raw = 7'h3F;
            4'd1:    raw = 7'h06;
            4'd2:    raw = 7'h5B;
            4'd3:    raw = 7'h4F;
            4'd4:    raw = 7'h66;
            4'd5:    raw = 7'h6D;
            4'd6:    raw = 7'h7D;
            4'd7:    raw = 7'h07;
            4'd8:    raw = 7'h7F;
            4'd9:    raw = 7'h6F;
            default: raw = 7'h00;
        endcase
        if (blank) raw = 7'h00;
        return SEG_ACT_LOW ? ~raw : raw;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLOCK50M) begin
        if (KEY0) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (counter_update) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = (upd_pend_q || counter_update) ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_idle  = (state_q == IDLE);
        in_shift = (state_q == SHIFT);
        in_done  = (state_q == DONE);
        busy     = !in_idle;
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        for (int i = 0; i < 4; i++)
            adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];

        // In DONE a same-cycle update is newer than anything held
        start     = (in_idle && counter_update) || (in_done && (upd_pend_q || counter_update));
        start_val = (in_done && !counter_update) ? hold_q : counter_in;

        sr_d        = sr_q;
        hold_d      = hold_q;
        scr_d       = scr_q;
        bcd_d       = bcd_q;
        lap_d       = lap_q;
        cnt_d       = cnt_q;
        upd_pend_d  = upd_pend_q;
        lap_pend_d  = lap_pend_q;
        lap_valid_d = lap_valid_q;
        done_d      = 1'b0;

        if (in_shift) begin
            scr_d = {adj[14:0], sr_q[IN_W-1]};
            sr_d  = sr_q << 1;
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            if (counter_update) begin
                upd_pend_d = 1'b1;
                hold_d     = counter_in;
            end
            if (write_100m) lap_pend_d = 1'b1;
        end

        if (in_done) begin
            bcd_d      = scr_q;
            done_d     = 1'b1;
            upd_pend_d = 1'b0;
            if (lap_pend_q || (write_100m && !counter_update)) begin
                lap_d       = scr_q;
                lap_valid_d = 1'b1;
            end
            lap_pend_d = write_100m && counter_update;
        end

        if (in_idle && write_100m) begin
            if (counter_update) begin
                lap_pend_d = 1'b1;
            end else begin
                lap_d       = bcd_q;
                lap_valid_d = 1'b1;
            end
        end

        if (start) begin
            sr_d  = start_val;
            scr_d = '0;
            cnt_d = CW'(IN_W - 1);
        end
    end

    // ---------------- display source and decode ----------------
    always_comb begin
        src    = (show_lap && lap_valid_q) ? lap_q : bcd_q;
        blank3 = BLANK_LEADING && (src[15:12] == 4'd0);
        blank2 = blank3 && (src[11:8] == 4'd0);
        hex_d[3] = seg7(src[15:12], blank3);
        hex_d[2] = seg7(src[11:8],  blank2);
        hex_d[1] = seg7(src[7:4],   1'b0);
        hex_d[0] = seg7(src[3:0],   1'b0);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLOCK50M) begin
        if (KEY0) begin
            sr_q        <= '0;
            hold_q      <= '0;
            scr_q       <= '0;
            bcd_q       <= '0;
            lap_q       <= '0;
            cnt_q       <= '0;
            upd_pend_q  <= 1'b0;
            lap_pend_q  <= 1'b0;
            lap_valid_q <= 1'b0;
            done_q      <= 1'b0;
            hex_q       <= {seg7(4'd0, BLANK_LEADING), seg7(4'd0, BLANK_LEADING),
                            seg7(4'd0, 1'b0), seg7(4'd0, 1'b0)};
        end else begin
            sr_q        <= sr_d;
            hold_q      <= hold_d;
            scr_q       <= scr_d;
            bcd_q       <= bcd_d;
            lap_q       <= lap_d;
            cnt_q       <= cnt_d;
            upd_pend_q  <= upd_pend_d;
            lap_pend_q  <= lap_pend_d;
            lap_valid_q <= lap_valid_d;
            done_q      <= done_d;
            hex_q       <= hex_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign lap_bcd   = lap_q;
    assign lap_valid = lap_valid_q;
    assign conv_done = done_q;
    assign HEX0      = hex_q[0];
    assign HEX1      = hex_q[1];
    assign HEX2      = hex_q[2];
    assign HEX3      = hex_q[3];

endmodule
